// File: rtl/otter_mem_arbiter_if.sv
// Bus bundle between the three memory requesters (I, D, X), the arbiter and the
// single-ported memory macro. The slave modport is the arbiter's view.
interface otter_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic [DATA_W-1:0] i_rdata;
  logic              i_rvld;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvld;

  logic              x_req;
  logic              x_we;
  logic [BE_W-1:0]   x_be;
  logic [ADDR_W-1:0] x_addr;
  logic [DATA_W-1:0] x_wdata;
  logic              x_gnt;
  logic [DATA_W-1:0] x_rdata;
  logic              x_rvld;

  logic              mem_en;
  logic              mem_we;
  logic [BE_W-1:0]   mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    input  x_req, x_we, x_be, x_addr, x_wdata,
    input  mem_rdata,
    output i_gnt, i_rdata, i_rvld,
    output d_gnt, d_rdata, d_rvld,
    output x_gnt, x_rdata, x_rvld,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_be, d_addr, d_wdata,
    output x_req, x_we, x_be, x_addr, x_wdata,
    output mem_rdata,
    input  i_gnt, i_rdata, i_rvld,
    input  d_gnt, d_rdata, d_rvld,
    input  x_gnt, x_rdata, x_rvld,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/otter_mem_arbiter.sv
// Three-way arbiter (D > I > X, X promoted after STARVE_LIMIT losing cycles)
// in front of a single-ported, 1-cycle-latency unified memory.

// Per-requester read return: live data in the return cycle, held afterwards.
module otter_mem_arbiter_rport #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              own_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvld_o
);
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)      rdata_q <= '0;
    else if (own_i) rdata_q <= mem_rdata_i;
  end

  assign rdata_o = own_i ? mem_rdata_i : rdata_q;
  assign rvld_o  = own_i;
endmodule

module otter_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input logic               clk,
  input logic               rst,
  otter_mem_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int NP   = 3;
  localparam int PI   = 0;
  localparam int PD   = 1;
  localparam int PX   = 2;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic {NORMAL, STARVED} mode_e;

  logic [NP-1:0]             req, gnt, own_d, own_q, rvld;
  req_t [NP-1:0]             rq;
  req_t                      sel;
  logic [NP-1:0][DATA_W-1:0] rdata;
  mode_e                     mode_q, mode_d;
  logic [7:0]                cnt_q, cnt_d;

  assign req    = {bus.x_req, bus.d_req, bus.i_req};
  assign rq[PI] = '{we: 1'b0, be: {BE_W{1'b1}}, addr: bus.i_addr, wdata: {DATA_W{1'b0}}};
  assign rq[PD] = '{we: bus.d_we, be: bus.d_be, addr: bus.d_addr, wdata: bus.d_wdata};
  assign rq[PX] = '{we: bus.x_we, be: bus.x_be, addr: bus.x_addr, wdata: bus.x_wdata};

  // Grant depends only on req and registered mode, never on mem_rdata.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (mode_q == STARVED && req[PX]) gnt[PX] = 1'b1;
      else if (req[PD])                 gnt[PD] = 1'b1;
      else if (req[PI])                 gnt[PI] = 1'b1;
      else if (req[PX])                 gnt[PX] = 1'b1;
    end
  end

  always_comb begin
    sel = '0;
    for (int p = 0; p < NP; p++)
      if (gnt[p]) sel = rq[p];
  end

  assign bus.mem_en    = |gnt;
  assign bus.mem_we    = sel.we;
  assign bus.mem_be    = sel.be;
  assign bus.mem_addr  = sel.addr;
  assign bus.mem_wdata = sel.wdata;
  assign own_d         = sel.we ? '0 : gnt;

  // X's losing streak; reaching the limit promotes X for the next cycle.
  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    if (!req[PX] || gnt[PX]) begin
      cnt_d  = '0;
      mode_d = NORMAL;
    end else begin
      if (cnt_q < LIMIT) cnt_d = cnt_q + 8'd1;
      if (cnt_d == LIMIT) mode_d = STARVED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= NORMAL;
      cnt_q  <= '0;
      own_q  <= '0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      own_q  <= own_d;
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_rport
    otter_mem_arbiter_rport #(.DATA_W(DATA_W)) u_rport (
      .clk_i      (clk),
      .rst_i      (rst),
      .own_i      (own_q[p]),
      .mem_rdata_i(bus.mem_rdata),
      .rdata_o    (rdata[p]),
      .rvld_o     (rvld[p])
    );
  end

  assign bus.i_gnt   = gnt[PI];
  assign bus.d_gnt   = gnt[PD];
  assign bus.x_gnt   = gnt[PX];
  assign bus.i_rdata = rdata[PI];
  assign bus.d_rdata = rdata[PD];
  assign bus.x_rdata = rdata[PX];
  assign bus.i_rvld  = rvld[PI];
  assign bus.d_rvld  = rvld[PD];
  assign bus.x_rvld  = rvld[PX];
endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Shares one single-ported, 1-cycle-latency unified memory between three requesters: the CPU instruction-fetch port (I), the CPU data port (D, loads and stores), and an external bus master (X, DMA or debug).
- Sits between the control-unit FSM's imem_r_en / dmem_r_en / dmem_w_en side and the memory macro.
- Fixed priority D > I > X, with a starvation counter that temporarily promotes X.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- STARVE_LIMIT, 8, number of consecutive cycles X may wait before it is promoted. Legal range 1..255.

Ports:
- clk  in  1  system clock; everything is on posedge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held until granted.
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rdata  out  DATA_W  fetch data.
- i_rvld  out  1  i_rdata valid.
- d_req  in  1  data request; held until granted.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  DATA_W/8  store byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data access accepted.
- d_rdata  out  DATA_W  load data.
- d_rvld  out  1  d_rdata valid.
- x_req, x_we, x_be, x_addr, x_wdata  in  as for D  external-master request.
- x_gnt, x_rdata, x_rvld  out  as for D  external-master response.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  read data, valid the cycle after a read is issued.

Behaviour:
- Handshake:
  - A requester raises req with stable attributes and holds them until it sees gnt high at a clock edge.
  - gnt is combinational in the same cycle and is a one-cycle pulse per access.
  - At most one gnt per cycle. The granted port's attributes are muxed onto mem_* and mem_en=1 that cycle.
  - With no req active: mem_en=0 and mem_we=0; mem_addr/mem_wdata/mem_be are don't-care (drive 0).
- I-port behaviour: I is read-only. Drive mem_we=0 and mem_be all-ones for I.
- Mode FSM, two states:
  - NORMAL: priority D > I > X.
  - STARVED: priority X > D > I.
  - NORMAL->STARVED when starve_cnt reaches STARVE_LIMIT at a clock edge.
  - STARVED->NORMAL on the edge where x_gnt=1, or when x_req drops.
- starve_cnt (8 bits):
  - Increments on each edge with x_req=1 and x_gnt=0; saturates at STARVE_LIMIT.
  - Cleared on x_gnt=1 or x_req=0.
- Read return:
  - A granted read (mem_we=0) registers an owner tag {I, D, X}.
  - Next cycle: mem_rdata routes to the owner's rdata and exactly that owner's rvld=1. The other rvld=0; non-owner rdata holds its last value.
  - Writes produce no rvld.
  - Back-to-back reads to different owners pipeline at full rate with no bubble.
- Reset values: all gnt 0, all rvld 0, all rdata 0, mem_en 0, mode NORMAL, starve_cnt 0, owner tag none.
- Reset mid-operation:
  - A read granted in the cycle rst is sampled produces no rvld afterwards.
  - Requests present during rst receive no gnt.
- Simultaneous events:
  - If all three req are high in NORMAL: D granted; I and X wait. I is served the next cycle if D drops.
  - D and I are never starved.
  - Starvation with STARVE_LIMIT=1: X waits exactly one losing cycle, then wins.
- Protocol violation (req dropped before gnt): tolerated. No grant is issued and no state is corrupted except starve_cnt clearing.
- Implementation constraints: no combinational path from mem_rdata to any gnt; no latches.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, mem_rdata=0xDEADBEEF next cycle -> i_gnt=1 and mem_addr=0x100 in cycle 0; i_rvld=1 and i_rdata=0xDEADBEEF in cycle 1; d_rvld=x_rvld=0.
- D over I: d_req load 0x200 and i_req 0x104 together -> d_gnt in cycle 0; i_gnt in cycle 1; d_rvld in cycle 1; i_rvld in cycle 2; correct data steering each cycle.
- Store: d_we=1, d_be=0b0011, d_addr=0x300, d_wdata=0x0000ABCD -> mem_en=mem_we=1 with matching be/addr/data in one cycle; no rvld the next cycle.
- Starvation: STARVE_LIMIT=3; i_req held continuously and x_req held from cycle 0 -> I granted cycles 0-2; x_gnt in cycle 3; starve_cnt back to 0 in cycle 4; I resumes.
- Reset mid-read: X read granted in the same cycle rst=1 -> x_rvld stays 0 the following cycle; all outputs at reset values.
- Random back-to-back: 1000 cycles of random req from all three ports against a reference model:
  - every granted read returns exactly one rvld to its owner one cycle later;
  - never more than one gnt per cycle;
  - X waits no more than STARVE_LIMIT+1 cycles.
